demux1to2_buf: RTL and testbench



---
 rtl/demux1to2_buf.sv | 98 +++++++++
 tb/tb_demux1to2_buf.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/demux1to2_buf.sv
// Buffered 1-to-2 demultiplexer: one valid/ready stream is steered by in_sel
// into channel A (sel=1) or channel B (sel=0), each backed by its own small FIFO.
module demux1to2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [AW:0]      a_count,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [AW:0]      b_count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  // Channel index 0 is A, index 1 is B.
  logic [1:0] chan_rdy;
  logic [1:0] chan_sel;
  logic [1:0] chan_full;
  logic       push_ok;

  assign chan_rdy = {b_ready, a_ready};
  assign chan_sel = {~in_sel, in_sel};

  // Acceptance looks only at the selected channel's occupancy, never at the
  // consumer ready, so a full FIFO cannot pass a word through on a pop.
  assign in_ready = in_sel ? ~chan_full[0] : ~chan_full[1];
  assign push_ok  = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [WIDTH-1:0] mem_d [DEPTH];
      logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
      logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
      logic [AW:0]      cnt_q, cnt_d;
      logic             push;
      logic             pop;
      logic [WIDTH-1:0] head;

      assign chan_full[gi] = (cnt_q == FULL_CNT);
      assign push          = push_ok & chan_sel[gi];
      assign pop           = (cnt_q != '0) & chan_rdy[gi];
      assign head          = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;

      always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
          mem_d[wr_ptr_q] = in_data;
          wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
        end
        cnt_d = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          cnt_q    <= cnt_d;
        end
      end

      // Storage needs no reset: the head is masked to zero whenever empty.
      always_ff @(posedge clk) begin
        mem_q <= mem_d;
      end
    end
  endgenerate

  assign a_data  = g_ch[0].head;
  assign a_count = g_ch[0].cnt_q;
  assign a_valid = (g_ch[0].cnt_q != '0);
  assign b_data  = g_ch[1].head;
  assign b_count = g_ch[1].cnt_q;
  assign b_valid = (g_ch[1].cnt_q != '0);

endmodule

// File: tb/tb_demux1to2_buf.sv
// Directed bench for demux1to2_buf: a queue-based channel model checked every
// cycle, plus hand-computed literal checks at key points of each scenario.
module tb_demux1to2_buf;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int AW    = 1;

  logic             clk = 0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [AW:0]      a_count;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [AW:0]      b_count;

  int errors = 0;
  int checks = 0;
  bit go = 0;

  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];

  demux1to2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready), .a_count(a_count),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready), .b_count(b_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel is an ordered queue bounded at DEPTH.
  always @(posedge clk) begin
    bit acc, pa, pb;
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      acc = in_valid && (in_sel ? (qa.size() < DEPTH) : (qb.size() < DEPTH));
      pa  = a_ready && (qa.size() > 0);
      pb  = b_ready && (qb.size() > 0);
      if (pa) void'(qa.pop_front());
      if (pb) void'(qb.pop_front());
      if (acc) begin
        if (in_sel) qa.push_back(in_data);
        else        qb.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (go) begin
      check("in_ready", 32'(in_ready),
            32'(in_sel ? (qa.size() != DEPTH) : (qb.size() != DEPTH)));
      check("a_valid", 32'(a_valid), 32'(qa.size() != 0));
      check("a_count", 32'(a_count), 32'(qa.size()));
      check("a_data",  a_data, (qa.size() != 0) ? qa[0] : 32'h0);
      check("b_valid", 32'(b_valid), 32'(qb.size() != 0));
      check("b_count", 32'(b_count), 32'(qb.size()));
      check("b_data",  b_data, (qb.size() != 0) ? qb[0] : 32'h0);
      $display("cyc t=%0t rst=%0b in v=%0b s=%0b d=%h rdy=%0b | A v=%0b c=%0d d=%h | B v=%0b c=%0d d=%h",
               $time, rst, in_valid, in_sel, in_data, in_ready,
               a_valid, a_count, a_data, b_valid, b_count, b_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; in_data = '0; in_sel = 0; in_valid = 0; a_ready = 0; b_ready = 0;
    step();
    go = 1;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_a_valid", 32'(a_valid), 32'd0);
    rst = 0;

    // 1: one word to each channel
    in_valid = 1; in_sel = 1; in_data = 32'h1111_0001; step();
    in_sel = 0; in_data = 32'h2222_0002; step();
    in_valid = 0;
    check("t1_a_data", a_data, 32'h1111_0001);
    check("t1_a_count", 32'(a_count), 32'd1);
    check("t1_b_data", b_data, 32'h2222_0002);
    check("t1_b_count", 32'(b_count), 32'd1);
    a_ready = 1; b_ready = 1; step();
    a_ready = 0; b_ready = 0;

    // 2: overfill A, third word held until A drains
    in_valid = 1; in_sel = 1;
    in_data = 32'hA000_0001; step();
    in_data = 32'hA000_0002; step();
    check("t2_a_count_full", 32'(a_count), 32'd2);
    check("t2_in_ready_sel1", 32'(in_ready), 32'd0);
    in_sel = 0; #1;
    check("t2_in_ready_sel0", 32'(in_ready), 32'd1);
    in_sel = 1; in_data = 32'hA000_0003; #1;
    step();
    check("t2_held_count", 32'(a_count), 32'd2);
    a_ready = 1; step();
    check("t2_pop1_head", a_data, 32'hA000_0002);
    step();
    check("t2_third_head", a_data, 32'hA000_0003);
    check("t2_third_count", 32'(a_count), 32'd1);
    in_valid = 0; step();
    a_ready = 0;
    check("t2_drained", 32'(a_count), 32'd0);

    // 3: simultaneous push and pop at count 1
    in_valid = 1; in_sel = 1; in_data = 32'hA000_0004; step();
    a_ready = 1; in_data = 32'hA000_0005; step();
    a_ready = 0;
    check("t3_count", 32'(a_count), 32'd1);
    check("t3_head", a_data, 32'hA000_0005);
    in_data = 32'hA000_0006; step();
    check("t3_full", 32'(a_count), 32'd2);

    // 4: A full, stream 8 words through B
    b_ready = 1; in_sel = 0;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'hB000_0000 + 32'(i); #1;
      check("t4_in_ready", 32'(in_ready), 32'd1);
      step();
      check("t4_b_head", b_data, 32'hB000_0000 + 32'(i));
    end
    in_valid = 0; step();
    b_ready = 0;
    check("t4_a_count", 32'(a_count), 32'd2);
    check("t4_a_data", a_data, 32'hA000_0005);

    // 5: alternate push/pop on B for pointer wrap
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_sel = 0; in_data = 32'(i); b_ready = 0; step();
      check("t5_b_data", b_data, 32'(i));
      in_valid = 0; b_ready = 1; step();
    end
    b_ready = 0;
    check("t5_b_empty", 32'(b_valid), 32'd0);

    // 6: reset with both full
    in_valid = 1; in_sel = 0;
    in_data = 32'hB100_0001; step();
    in_data = 32'hB100_0002; step();
    in_valid = 0;
    check("t6_b_full", 32'(b_count), 32'd2);
    rst = 1; step();
    check("t6_a_valid", 32'(a_valid), 32'd0);
    check("t6_b_valid", 32'(b_valid), 32'd0);
    check("t6_a_count", 32'(a_count), 32'd0);
    check("t6_b_count", 32'(b_count), 32'd0);
    check("t6_a_data", a_data, 32'h0);
    check("t6_b_data", b_data, 32'h0);
    rst = 0;
    in_valid = 1; in_sel = 1; in_data = 32'hC000_0001; step();
    in_valid = 0;
    check("t6_post_a_data", a_data, 32'hC000_0001);
    check("t6_post_a_count", 32'(a_count), 32'd1);
    step();

    @(negedge clk);
    go = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
